// File: rtl/pinball_pkg.sv
// Shared types for the pinball collision logic.
// Collision type bundle, FSM states and counter width.
package pinball_pkg;

  localparam int CNT_W = 8;

  // bit0 = smiley/flipper, bit1 = smiley/frame
  typedef struct packed {
    logic sb;
    logic sf;
  } col_type_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Per-frame saturating overlap counter.
// load restarts the count with this cycle's pixel.
module sat_counter
  import pinball_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Restart on frame start, otherwise count up and stick at all-ones
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= {{(CNT_W-1){1'b0}}, inc};
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/collision_ctrl.sv
// Frame-based collision reporter with valid/ack handshake.
// Define COLLISION_PRIORITY_EN to add the col_first output.
module collision_ctrl
  import pinball_pkg::*;
#(
  parameter int MIN_PIXELS = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       draw_smiley,
  input  logic       draw_flipper,
  input  logic       draw_frame,
  input  logic       col_ack,
  output logic       col_valid,
  output logic [1:0] col_type,
  output logic       col_overrun
`ifdef COLLISION_PRIORITY_EN
  ,
  output logic [1:0] col_first
`endif
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PIXELS);

  logic             w_sf_px;
  logic             w_sb_px;
  logic [CNT_W-1:0] w_sf_cnt;
  logic [CNT_W-1:0] w_sb_cnt;
  col_type_t        w_type;
  logic             w_ack;

  state_t    r_state;
  logic      r_valid;
  col_type_t r_type;
  logic      r_ovr;

  assign w_sf_px = draw_smiley & draw_flipper;
  assign w_sb_px = draw_smiley & draw_frame;

  sat_counter u_sf (
    .clk    (clk),
    .resetN (resetN),
    .load   (startOfFrame),
    .inc    (w_sf_px),
    .count  (w_sf_cnt)
  );

  sat_counter u_sb (
    .clk    (clk),
    .resetN (resetN),
    .load   (startOfFrame),
    .inc    (w_sb_px),
    .count  (w_sb_cnt)
  );

  // Type of the frame that is ending, from pre-clear counts
  assign w_type.sf = (w_sf_cnt >= MIN_C);
  assign w_type.sb = (w_sb_cnt >= MIN_C);
  assign w_ack     = col_ack & r_valid;

  // Report FSM: publish on frame end, retire on ack
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_type  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (startOfFrame) r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (startOfFrame && (w_type != '0)) begin
            r_state <= S_REPORT;
            r_valid <= 1'b1;
            r_type  <= w_type;
          end
        end
        S_REPORT: begin
          if (startOfFrame && (w_type != '0)) begin
            r_type <= w_type;
            if (!w_ack) r_ovr <= 1'b1;
          end else if (w_ack) begin
            r_valid <= 1'b0;
            r_state <= S_SCAN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign col_valid   = r_valid;
  assign col_type    = r_type;
  assign col_overrun = r_ovr;

`ifdef COLLISION_PRIORITY_EN
  logic [1:0] w_px;
  logic       w_load;
  logic [1:0] r_frame_first;
  logic [1:0] r_first;

  assign w_px   = {w_sb_px, w_sf_px};
  assign w_load = startOfFrame && (w_type != '0) && (r_state != S_IDLE);

  // Latch the first overlap of each frame; publish it with the report
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frame_first <= 2'b00;
      r_first       <= 2'b00;
    end else begin
      if (w_load) r_first <= r_frame_first;
      if (startOfFrame || (r_frame_first == 2'b00)) r_frame_first <= w_px;
    end
  end

  assign col_first = r_first;
`endif

endmodule

// File: tb/tb_collision_ctrl.sv
// Bench for collision_ctrl: vector table, directed corners,
// and random traffic against a frame-level reference model.
module tb_collision_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN = 1'b0;
  logic sof = 1'b0, ds = 1'b0, df = 1'b0, db = 1'b0, ack = 1'b0;
  logic va, vb, oa, ob;
  logic [1:0] ta, tb2;
`ifdef COLLISION_PRIORITY_EN
  logic [1:0] fa, fb;
`endif

  collision_ctrl #(.MIN_PIXELS(1)) dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .draw_smiley(ds), .draw_flipper(df), .draw_frame(db),
    .col_ack(ack), .col_valid(va), .col_type(ta),
    .col_overrun(oa)
`ifdef COLLISION_PRIORITY_EN
    , .col_first(fa)
`endif
  );

  collision_ctrl #(.MIN_PIXELS(4)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .draw_smiley(ds), .draw_flipper(df), .draw_frame(db),
    .col_ack(ack), .col_valid(vb), .col_type(tb2),
    .col_overrun(ob)
`ifdef COLLISION_PRIORITY_EN
    , .col_first(fb)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: index 0 = MIN 1, index 1 = MIN 4
  int         mmin[2] = '{1, 4};
  bit         m_run[2];
  bit         m_v[2];
  bit         m_o[2];
  logic [1:0] m_t[2];
  logic [1:0] m_ff[2];
  logic [1:0] m_cf[2];
  int         m_sf[2];
  int         m_sb[2];

  function automatic void mreset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_v[i] = 0; m_o[i] = 0;
      m_t[i] = 0; m_ff[i] = 0; m_cf[i] = 0;
      m_sf[i] = 0; m_sb[i] = 0;
    end
  endfunction

  function automatic void mstep();
    bit psf;
    bit psb;
    logic [1:0] px;
    logic [1:0] t;
    bit a;
    psf = ds & df;
    psb = ds & db;
    px = {psb, psf};
    for (int i = 0; i < 2; i++) begin
      t = {m_sb[i] >= mmin[i], m_sf[i] >= mmin[i]};
      a = ack && m_v[i];
      if (sof) begin
        if (!m_run[i]) m_run[i] = 1;
        else if (t != 0) begin
          if (m_v[i] && !a) m_o[i] = 1;
          m_v[i] = 1;
          m_t[i] = t;
          m_cf[i] = m_ff[i];
        end else if (a) m_v[i] = 0;
        m_sf[i] = int'(psf);
        m_sb[i] = int'(psb);
        m_ff[i] = px;
      end else begin
        if (a) m_v[i] = 0;
        m_sf[i] += int'(psf);
        m_sb[i] += int'(psb);
        if (m_ff[i] == 0) m_ff[i] = px;
      end
    end
  endfunction

  task automatic mcheck(input string tag);
    chk({tag, ".va"}, va, m_v[0]);
    chk({tag, ".oa"}, oa, m_o[0]);
    if (m_v[0]) chk({tag, ".ta"}, ta, m_t[0]);
    chk({tag, ".vb"}, vb, m_v[1]);
    chk({tag, ".ob"}, ob, m_o[1]);
    if (m_v[1]) chk({tag, ".tb"}, tb2, m_t[1]);
`ifdef COLLISION_PRIORITY_EN
    if (m_v[0]) chk({tag, ".fa"}, fa, m_cf[0]);
    if (m_v[1]) chk({tag, ".fb"}, fb, m_cf[1]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    mstep();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    {sof, ds, df, db, ack} = 5'b0;
    mreset();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic px(input logic s, input logic f,
                    input logic b, input logic so,
                    input logic ak);
    sof = so; ds = s; df = f; db = b; ack = ak;
    tick();
  endtask

  typedef struct {
    bit sof, s, f, b, ack;
    bit ev;
    logic [1:0] et;
    bit eo;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 2'b00, 0};
    tbl[1]  = '{0, 1, 1, 0, 0, 0, 2'b00, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 0, 2'b00, 0};
    tbl[3]  = '{0, 1, 1, 0, 0, 0, 2'b00, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 2'b00, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 1, 2'b01, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 2'b01, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 0, 2'b00, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 0, 2'b00, 0};
    tbl[9]  = '{0, 1, 0, 1, 0, 0, 2'b00, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 2'b10, 0};
    tbl[11] = '{0, 1, 1, 1, 0, 1, 2'b10, 0};
    tbl[12] = '{1, 0, 0, 0, 1, 1, 2'b11, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 1, 2'b11, 0};
    tbl[14] = '{0, 0, 0, 0, 1, 0, 2'b00, 0};

    @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("rst.va", va, 0);
    chk("rst.ta", ta, 0);
    chk("rst.oa", oa, 0);
    chk("rst.vb", vb, 0);

    // Vector table on the MIN_PIXELS=1 instance
    for (int i = 0; i < 15; i++) begin
      px(tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].sof, tbl[i].ack);
      chk($sformatf("tbl%0d.v", i), va, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d.t", i), ta, tbl[i].et);
      chk($sformatf("tbl%0d.o", i), oa, tbl[i].eo);
    end

    // Threshold on the MIN_PIXELS=4 instance
    do_reset();
    px(0, 0, 0, 1, 0);
    repeat (3) px(1, 0, 1, 0, 0);
    px(0, 0, 0, 1, 0);
    chk("min4.three", vb, 0);
    repeat (4) px(1, 0, 1, 0, 0);
    px(0, 0, 0, 1, 0);
    chk("min4.four.v", vb, 1);
    chk("min4.four.t", tb2, 2'b10);

    // Overwrite before ack sets sticky overrun
    do_reset();
    px(0, 0, 0, 1, 0);
    px(1, 1, 0, 0, 0);
    px(0, 0, 0, 1, 0);
    chk("ovr.first.t", ta, 2'b01);
    chk("ovr.first.o", oa, 0);
    px(1, 0, 1, 0, 0);
    px(0, 0, 0, 1, 0);
    chk("ovr.second.t", ta, 2'b10);
    chk("ovr.second.o", oa, 1);
    px(0, 0, 0, 0, 1);
    chk("ovr.ack.v", va, 0);
    chk("ovr.ack.o", oa, 1);
    px(0, 0, 0, 0, 0);
    chk("ovr.hold.o", oa, 1);

    // Saturation over a long overlap
    do_reset();
    px(1, 1, 0, 1, 0);
    repeat (299) px(1, 1, 0, 0, 0);
    chk("sat.a.cnt", dut_a.u_sf.count, 255);
    chk("sat.b.cnt", dut_b.u_sf.count, 255);
    px(0, 0, 0, 1, 0);
    chk("sat.a.v", va, 1);
    chk("sat.a.t", ta, 2'b01);
    chk("sat.b.v", vb, 1);
    chk("sat.b.t", tb2, 2'b01);

    // Asynchronous reset with a pending report
    do_reset();
    px(0, 0, 0, 1, 0);
    px(1, 1, 1, 0, 0);
    px(0, 0, 0, 1, 0);
    chk("arst.pre.v", va, 1);
    px(1, 1, 1, 0, 0);
    #2 resetN = 1'b0;
    #1;
    chk("arst.v", va, 0);
    chk("arst.t", ta, 0);
    chk("arst.o", oa, 0);
    chk("arst.cnt", dut_a.u_sf.count, 0);
    mreset();
    {sof, ds, df, db, ack} = 5'b0;
    @(negedge clk);
    resetN = 1'b1;
    px(0, 0, 0, 1, 0);
    chk("arst.sof1.v", va, 0);
    px(0, 0, 0, 1, 0);
    chk("arst.sof2.v", va, 0);

`ifdef COLLISION_PRIORITY_EN
    // First-overlap priority
    do_reset();
    px(0, 0, 0, 1, 0);
    for (int p = 1; p < 60; p++)
      px(p == 10 || p == 50, p == 50, p == 10, 0, 0);
    px(0, 0, 0, 1, 0);
    chk("prio.first", fa, 2'b10);
    chk("prio.type", ta, 2'b11);
`endif

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sof = ($urandom % 16) == 0;
      ds  = $urandom % 2;
      df  = $urandom % 2;
      db  = $urandom % 2;
      ack = ($urandom % 3) == 0;
      tick();
      mcheck($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
